interrupt_ctrl: RTL and testbench

- Interrupt factor/mask controller directly downstream of the programmable timer, clock timer, stopwatch, serial and K-port input blocks.
- Captures single-cycle factor-set pulses into read-to-clear factor registers (0xF00-0xF05) and holds software masks (0xF10-0xF15).
- Drives a registered interrupt request to the CPU core with a priority-encoded vector, frozen by an acknowledge handshake.

---
 rtl/interrupt_ctrl_if.sv | 27 ++
 rtl/interrupt_ctrl.sv | 209 ++++++++++++++++++++
 tb/tb_interrupt_ctrl.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/interrupt_ctrl_if.sv
// Bus and interrupt signals between the CPU core and interrupt_ctrl.
// master = core side, slave = controller side.
interface interrupt_ctrl_if;
  logic [11:0] bus_addr;
  logic        bus_read_en;
  logic        bus_write_en;
  logic [3:0]  bus_wdata;
  logic [3:0]  bus_rdata;
  logic        bus_rdata_valid;
  logic        irq;
  logic [7:0]  irq_vector;
  logic        irq_ack;

  modport master (
    output bus_addr, bus_read_en, bus_write_en,
    output bus_wdata, irq_ack,
    input  bus_rdata, bus_rdata_valid,
    input  irq, irq_vector
  );

  modport slave (
    input  bus_addr, bus_read_en, bus_write_en,
    input  bus_wdata, irq_ack,
    output bus_rdata, bus_rdata_valid,
    output irq, irq_vector
  );
endinterface

// File: rtl/interrupt_ctrl.sv
// Interrupt factor/mask controller with priority vector and ack handshake.
// Define INT_SERIAL_EN to implement the serial factor/mask/vector.
module interrupt_ctrl #(
  parameter logic [3:0] VECTOR_PAGE = 4'h1
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [3:0] clk_timer_factor_set,
  input  logic [1:0] stopwatch_factor_set,
  input  logic       prog_timer_factor_set,
  input  logic       serial_factor_set,
  input  logic       k0_factor_set,
  input  logic       k1_factor_set,
  interrupt_ctrl_if.slave bus
);

`ifdef INT_SERIAL_EN
  localparam logic SER_EN = 1'b1;
`else
  localparam logic SER_EN = 1'b0;
`endif

  localparam logic [11:0] A_F00 = 12'hF00;
  localparam logic [11:0] A_F01 = 12'hF01;
  localparam logic [11:0] A_F02 = 12'hF02;
  localparam logic [11:0] A_F03 = 12'hF03;
  localparam logic [11:0] A_F04 = 12'hF04;
  localparam logic [11:0] A_F05 = 12'hF05;
  localparam logic [11:0] A_F10 = 12'hF10;
  localparam logic [11:0] A_F11 = 12'hF11;
  localparam logic [11:0] A_F12 = 12'hF12;
  localparam logic [11:0] A_F13 = 12'hF13;
  localparam logic [11:0] A_F14 = 12'hF14;
  localparam logic [11:0] A_F15 = 12'hF15;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    ACKED
  } state_t;

  // The page nibble is prepended by the core's fetch path.
  logic unused_page;
  assign unused_page = ^VECTOR_PAGE;

  logic [3:0] fac_clk, msk_clk;
  logic [1:0] fac_sw, msk_sw;
  logic       fac_prog, msk_prog;
  logic       fac_ser, msk_ser;
  logic       fac_k0, msk_k0;
  logic       fac_k1, msk_k1;

  logic       ser_set;
  logic [3:0] rd_val;
  logic       rd_hit;
  logic       rd;
  logic [3:0] p_clk;
  logic [1:0] p_sw;
  logic       p_prog, p_ser, p_k0, p_k1;
  logic       pending;
  logic [7:0] vec_next;
  state_t     state;

  assign ser_set = serial_factor_set & SER_EN;
  assign rd      = bus.bus_read_en;

  assign p_clk   = fac_clk & msk_clk;
  assign p_sw    = fac_sw & msk_sw;
  assign p_prog  = fac_prog & msk_prog;
  assign p_ser   = fac_ser & msk_ser;
  assign p_k0    = fac_k0 & msk_k0;
  assign p_k1    = fac_k1 & msk_k1;
  assign pending = |{p_clk, p_sw, p_prog, p_ser, p_k0, p_k1};

  // Read-data mux and address decode
  always_comb begin
    rd_hit = 1'b1;
    rd_val = 4'h0;
    case (bus.bus_addr)
      A_F00:   rd_val = fac_clk;
      A_F01:   rd_val = {2'b00, fac_sw};
      A_F02:   rd_val = {3'b000, fac_prog};
      A_F03:   rd_val = {3'b000, fac_ser};
      A_F04:   rd_val = {3'b000, fac_k0};
      A_F05:   rd_val = {3'b000, fac_k1};
      A_F10:   rd_val = msk_clk;
      A_F11:   rd_val = {2'b00, msk_sw};
      A_F12:   rd_val = {3'b000, msk_prog};
      A_F13:   rd_val = {3'b000, msk_ser};
      A_F14:   rd_val = {3'b000, msk_k0};
      A_F15:   rd_val = {3'b000, msk_k1};
      default: rd_hit = 1'b0;
    endcase
  end

  // Highest-priority pending source to vector
  always_comb begin
    vec_next = 8'h00;
    if (p_prog)      vec_next = 8'h0C;
    else if (p_ser)  vec_next = 8'h0A;
    else if (p_k0)   vec_next = 8'h06;
    else if (p_k1)   vec_next = 8'h08;
    else if (|p_sw)  vec_next = 8'h04;
    else if (|p_clk) vec_next = 8'h02;
  end

  // Factor capture; a same-edge set beats the read-clear
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fac_clk  <= '0;
      fac_sw   <= '0;
      fac_prog <= 1'b0;
      fac_ser  <= 1'b0;
      fac_k0   <= 1'b0;
      fac_k1   <= 1'b0;
    end else begin
      fac_clk  <= ((rd && bus.bus_addr == A_F00) ? 4'h0 : fac_clk)
                  | clk_timer_factor_set;
      fac_sw   <= ((rd && bus.bus_addr == A_F01) ? 2'h0 : fac_sw)
                  | stopwatch_factor_set;
      fac_prog <= ((rd && bus.bus_addr == A_F02) ? 1'b0 : fac_prog)
                  | prog_timer_factor_set;
      fac_ser  <= ((rd && bus.bus_addr == A_F03) ? 1'b0 : fac_ser)
                  | ser_set;
      fac_k0   <= ((rd && bus.bus_addr == A_F04) ? 1'b0 : fac_k0)
                  | k0_factor_set;
      fac_k1   <= ((rd && bus.bus_addr == A_F05) ? 1'b0 : fac_k1)
                  | k1_factor_set;
    end
  end

  // Mask register writes
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      msk_clk  <= '0;
      msk_sw   <= '0;
      msk_prog <= 1'b0;
      msk_ser  <= 1'b0;
      msk_k0   <= 1'b0;
      msk_k1   <= 1'b0;
    end else if (bus.bus_write_en) begin
      case (bus.bus_addr)
        A_F10:   msk_clk  <= bus.bus_wdata;
        A_F11:   msk_sw   <= bus.bus_wdata[1:0];
        A_F12:   msk_prog <= bus.bus_wdata[0];
        A_F13:   msk_ser  <= bus.bus_wdata[0] & SER_EN;
        A_F14:   msk_k0   <= bus.bus_wdata[0];
        A_F15:   msk_k1   <= bus.bus_wdata[0];
        default: ;
      endcase
    end
  end

  // Registered read data; undecoded reads leave rdata untouched
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bus.bus_rdata       <= 4'h0;
      bus.bus_rdata_valid <= 1'b0;
    end else if (rd && rd_hit) begin
      bus.bus_rdata       <= rd_val;
      bus.bus_rdata_valid <= 1'b1;
    end else begin
      bus.bus_rdata_valid <= 1'b0;
    end
  end

  // Request/acknowledge FSM with registered irq and vector
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= IDLE;
      bus.irq        <= 1'b0;
      bus.irq_vector <= 8'h00;
    end else begin
      unique case (state)
        IDLE: begin
          bus.irq <= 1'b0;
          if (pending) begin
            state          <= REQ;
            bus.irq        <= 1'b1;
            bus.irq_vector <= vec_next;
          end
        end
        REQ: begin
          if (!pending) begin
            state   <= IDLE;
            bus.irq <= 1'b0;
          end else begin
            bus.irq_vector <= vec_next;
            if (bus.irq_ack) begin
              state   <= ACKED;
              bus.irq <= 1'b0;
            end else begin
              bus.irq <= 1'b1;
            end
          end
        end
        ACKED: begin
          bus.irq <= 1'b0;
          if (!bus.irq_ack) state <= IDLE;
        end
        default: begin
          state   <= IDLE;
          bus.irq <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_interrupt_ctrl.sv
// Scoreboard bench for interrupt_ctrl: reads and irq/vector changes
// are queued by the stimulus and checked by a negedge monitor.
module tb_interrupt_ctrl;

`ifdef INT_SERIAL_EN
  localparam logic [3:0] SER_EXP = 4'h1;
`else
  localparam logic [3:0] SER_EXP = 4'h0;
`endif

  logic       clk = 1'b0;
  logic       reset_n;
  logic [3:0] clk_set;
  logic [1:0] sw_set;
  logic       prog_set, ser_set, k0_set, k1_set;

  interrupt_ctrl_if bus ();

  interrupt_ctrl #(.VECTOR_PAGE(4'h1)) dut (
    .clk                   (clk),
    .reset_n               (reset_n),
    .clk_timer_factor_set  (clk_set),
    .stopwatch_factor_set  (sw_set),
    .prog_timer_factor_set (prog_set),
    .serial_factor_set     (ser_set),
    .k0_factor_set         (k0_set),
    .k1_factor_set         (k1_set),
    .bus                   (bus.slave)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  logic [3:0] rq[$];
  string      rn[$];
  logic [8:0] evq[$];
  string      en[$];
  logic [8:0] prev_ev = 9'h000;

  // Monitor: pop and compare on every read response and irq change
  always @(negedge clk) begin
    logic [8:0] cur;
    logic [3:0] er;
    logic [8:0] ee;
    string      nm;
    if (bus.bus_rdata_valid === 1'b1) begin
      tests++;
      if (rq.size() == 0) begin
        fails++;
        $display("FAIL rd_unexpected: got rdata=%h, required no response",
                 bus.bus_rdata);
      end else begin
        er = rq.pop_front();
        nm = rn.pop_front();
        if (bus.bus_rdata !== er) begin
          fails++;
          $display("FAIL %s: got rdata=%h, required %h", nm, bus.bus_rdata, er);
        end
      end
    end
    cur = {bus.irq, bus.irq_vector};
    if (cur !== prev_ev) begin
      tests++;
      if (evq.size() == 0) begin
        fails++;
        $display("FAIL ev_unexpected: got irq=%b vec=%h, required no change",
                 cur[8], cur[7:0]);
      end else begin
        ee = evq.pop_front();
        nm = en.pop_front();
        if (cur !== ee) begin
          fails++;
          $display("FAIL %s: got irq=%b vec=%h, required irq=%b vec=%h",
                   nm, cur[8], cur[7:0], ee[8], ee[7:0]);
        end
      end
      prev_ev = cur;
    end
  end

  task automatic chk(input string n, input logic [31:0] got,
                     input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, required %0h", n, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wr(input logic [11:0] a, input logic [3:0] d);
    bus.bus_addr     = a;
    bus.bus_wdata    = d;
    bus.bus_write_en = 1'b1;
    @(negedge clk);
    bus.bus_write_en = 1'b0;
  endtask

  task automatic rd(input logic [11:0] a, input logic [3:0] e,
                    input string n);
    rq.push_back(e);
    rn.push_back(n);
    bus.bus_addr    = a;
    bus.bus_read_en = 1'b1;
    @(negedge clk);
    bus.bus_read_en = 1'b0;
  endtask

  task automatic ev(input logic i, input logic [7:0] v, input string n);
    evq.push_back({i, v});
    en.push_back(n);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: timeout, required finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    reset_n          = 1'b0;
    clk_set          = 4'h0;
    sw_set           = 2'h0;
    prog_set         = 1'b0;
    ser_set          = 1'b0;
    k0_set           = 1'b0;
    k1_set           = 1'b0;
    bus.bus_addr     = 12'h000;
    bus.bus_read_en  = 1'b0;
    bus.bus_write_en = 1'b0;
    bus.bus_wdata    = 4'h0;
    bus.irq_ack      = 1'b0;
    #1;
    chk("rst_irq", {31'd0, bus.irq}, 0);
    chk("rst_vec", {24'd0, bus.irq_vector}, 0);
    chk("rst_valid", {31'd0, bus.bus_rdata_valid}, 0);
    chk("rst_rdata", {28'd0, bus.bus_rdata}, 0);
    cyc(2);
    reset_n = 1'b1;
    cyc(1);

    // prog interrupt, ack freezes vector
    wr(12'hF12, 4'h1);
    ev(1'b1, 8'h0C, "prog_req");
    prog_set = 1'b1;
    @(negedge clk);
    prog_set = 1'b0;
    @(negedge clk);
    chk("prog_irq_2cyc", {31'd0, bus.irq}, 1);
    cyc(2);
    ev(1'b0, 8'h0C, "prog_ack");
    bus.irq_ack = 1'b1;
    cyc(2);
    rd(12'hF02, 4'h1, "prog_clr_rd");
    bus.irq_ack = 1'b0;
    cyc(3);

    // masked prog: factor visible, read clears it
    wr(12'hF12, 4'h0);
    prog_set = 1'b1;
    @(negedge clk);
    prog_set = 1'b0;
    cyc(2);
    rd(12'hF02, 4'h1, "masked_rd1");
    rd(12'hF02, 4'h0, "masked_rd2");

    // read and set collide: set wins
    rq.push_back(4'h0);
    rn.push_back("coll_rd");
    bus.bus_addr    = 12'hF02;
    bus.bus_read_en = 1'b1;
    prog_set        = 1'b1;
    @(negedge clk);
    bus.bus_read_en = 1'b0;
    prog_set        = 1'b0;
    rd(12'hF02, 4'h1, "coll_rd_next");

    // serial factor/mask, optional
    wr(12'hF13, 4'h1);
    rd(12'hF13, SER_EXP, "ser_mask_rd");
    wr(12'hF13, 4'h0);
    ser_set = 1'b1;
    @(negedge clk);
    ser_set = 1'b0;
    rd(12'hF03, SER_EXP, "ser_fac_rd");

    // factor writes are ignored
    wr(12'hF04, 4'h1);
    rd(12'hF04, 4'h0, "fac_wr_ign");

    // mask widths, undecoded read
    wr(12'hF10, 4'hF);
    wr(12'hF11, 4'hF);
    rd(12'hF10, 4'hF, "msk_f10");
    rd(12'hF11, 4'h3, "msk_f11_width");
    bus.bus_addr    = 12'hF06;
    bus.bus_read_en = 1'b1;
    @(negedge clk);
    bus.bus_read_en = 1'b0;
    chk("undec_hold", {28'd0, bus.bus_rdata}, 32'h3);
    wr(12'hF12, 4'h1);
    rd(12'hF12, 4'h1, "msk_f12");

    // stopwatch over clock timer
    ev(1'b1, 8'h04, "sw_req");
    clk_set = 4'b0100;
    sw_set  = 2'b01;
    @(negedge clk);
    clk_set = 4'h0;
    sw_set  = 2'h0;
    cyc(3);
    ev(1'b1, 8'h02, "clk_vec");
    rd(12'hF01, 4'h1, "sw_fac_rd");
    cyc(3);
    ev(1'b0, 8'h02, "clk_drop");
    rd(12'hF00, 4'h4, "clk_fac_rd");
    cyc(3);

    // k0 over k1, re-request after ack
    wr(12'hF14, 4'h1);
    wr(12'hF15, 4'h1);
    ev(1'b1, 8'h06, "k0_req");
    k0_set = 1'b1;
    k1_set = 1'b1;
    @(negedge clk);
    k0_set = 1'b0;
    k1_set = 1'b0;
    cyc(3);
    ev(1'b0, 8'h06, "k0_ack");
    bus.irq_ack = 1'b1;
    cyc(2);
    rd(12'hF04, 4'h1, "k0_fac_rd");
    ev(1'b1, 8'h08, "k1_rereq");
    bus.irq_ack = 1'b0;
    cyc(4);

    // async reset while requesting
    ev(1'b0, 8'h00, "rst_in_req");
    #2;
    reset_n = 1'b0;
    #1;
    chk("rst_async_irq", {31'd0, bus.irq}, 0);
    chk("rst_async_vec", {24'd0, bus.irq_vector}, 0);
    cyc(2);
    reset_n = 1'b1;
    cyc(5);
    chk("post_rst_irq", {31'd0, bus.irq}, 0);
    rd(12'hF05, 4'h0, "post_rst_f05");
    rd(12'hF14, 4'h0, "post_rst_f14");
    rd(12'hF15, 4'h0, "post_rst_f15");
    rd(12'hF12, 4'h0, "post_rst_f12");
    cyc(3);

    chk("rd_queue_empty", rq.size(), 0);
    chk("ev_queue_empty", evq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
